// File: rtl/fwd_hazard_unit_param.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit_param
// Forwarding and load-use hazard unit for the pipelined RISC-V core.
// A shadow pipeline S[0..FWD_STAGES] (S[0] = EX) records the destination of
// every in-flight instruction. For each source of the instruction in EX the
// unit picks the nearest later stage whose result can be forwarded. It stalls
// ID while a load it depends on has not yet reached a forwardable stage.
//
// Ports
//   clk_i          clock
//   rst_i          asynchronous reset, active-low
//   hold_i         global freeze; every register (including the counter) holds
//   flush_i        kill the instruction in ID; overrides a stall
//   id_valid_i     ID holds a valid instruction
//   id_rs_i        ID source registers, source i at [i*REG_AW +: REG_AW]
//   id_rs_used_i   source i is actually read
//   id_rd_i        ID destination register
//   id_regwrite_i  ID instruction writes rd
//   id_is_load_i   ID instruction is a load
//   ex_fwd_sel_o   per EX source: 0 = regfile, k = forward from stage S[k]
//   stall_o        hold PC and IF/ID; a bubble enters EX
//   stall_cnt_o    saturating count of stall cycles
// -----------------------------------------------------------------------------
module fwd_hazard_unit_param #(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 32,
  localparam int SEL_W     = $clog2(FWD_STAGES + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        hold_i,
  input  logic                        flush_i,
  input  logic                        id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0]   id_rs_i,
  input  logic [NUM_SRC-1:0]          id_rs_used_i,
  input  logic [REG_AW-1:0]           id_rd_i,
  input  logic                        id_regwrite_i,
  input  logic                        id_is_load_i,
  output logic [NUM_SRC*SEL_W-1:0]    ex_fwd_sel_o,
  output logic                        stall_o,
  output logic [CNT_W-1:0]            stall_cnt_o
);

  // Shadow pipeline, index 0 is EX.
  logic [FWD_STAGES:0]         valid_r;
  logic [FWD_STAGES:0]         regwrite_r;
  logic [FWD_STAGES:0]         is_load_r;
  logic [REG_AW-1:0]           rd_r [0:FWD_STAGES];
  // Source operands of the instruction in EX.
  logic [NUM_SRC*REG_AW-1:0]   ex_rs_r;
  logic [NUM_SRC-1:0]          ex_used_r;
  logic [CNT_W-1:0]            stall_cnt_r;

  logic [FWD_STAGES:0]         live_s;
  logic [NUM_SRC*SEL_W-1:0]    fwd_sel_s;
  logic                        hit_s;
  logic                        stall_s;
  logic                        enter_s;

  // A stage carries a result only if it is valid, writes, and is not x0.
  always_comb begin
    live_s = {(FWD_STAGES+1){1'b0}};
    for (int k = 0; k <= FWD_STAGES; k++) begin
      live_s[k] = valid_r[k] & regwrite_r[k] & (rd_r[k] != {REG_AW{1'b0}});
    end
  end

  // Forward select per EX source. Stages are scanned oldest to nearest so the
  // nearest matching stage overwrites any older one. A load is only usable
  // once it has passed LOAD_LAT stages beyond EX.
  always_comb begin
    fwd_sel_s = {(NUM_SRC*SEL_W){1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = FWD_STAGES; k >= 1; k--) begin
        fwd_sel_s[i*SEL_W +: SEL_W] =
          (ex_used_r[i] && live_s[k] &&
           (rd_r[k] == ex_rs_r[i*REG_AW +: REG_AW]) &&
           (!is_load_r[k] || (k >= LOAD_LAT + 1)))
          ? SEL_W'(k) : fwd_sel_s[i*SEL_W +: SEL_W];
      end
    end
  end

  // Load-use detection: an ID source matches a load still in S[0..LOAD_LAT-1].
  always_comb begin
    hit_s = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        hit_s = hit_s | (live_s[k] & is_load_r[k] & id_rs_used_i[i] &
                         (rd_r[k] == id_rs_i[i*REG_AW +: REG_AW]));
      end
    end
    stall_s = id_valid_i & ~flush_i & hit_s;
    enter_s = id_valid_i & ~flush_i & ~stall_s;
  end

  // Shadow pipeline advance; a killed or stalled ID slot becomes a bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_r    <= {(FWD_STAGES+1){1'b0}};
      regwrite_r <= {(FWD_STAGES+1){1'b0}};
      is_load_r  <= {(FWD_STAGES+1){1'b0}};
      for (int k = 0; k <= FWD_STAGES; k++) begin
        rd_r[k] <= {REG_AW{1'b0}};
      end
      ex_rs_r    <= {(NUM_SRC*REG_AW){1'b0}};
      ex_used_r  <= {NUM_SRC{1'b0}};
    end else if (!hold_i) begin
      valid_r    <= {valid_r[FWD_STAGES-1:0], enter_s};
      regwrite_r <= {regwrite_r[FWD_STAGES-1:0], enter_s & id_regwrite_i};
      is_load_r  <= {is_load_r[FWD_STAGES-1:0], enter_s & id_is_load_i};
      for (int k = FWD_STAGES; k >= 1; k--) begin
        rd_r[k] <= rd_r[k-1];
      end
      rd_r[0]    <= enter_s ? id_rd_i : {REG_AW{1'b0}};
      ex_rs_r    <= enter_s ? id_rs_i : {(NUM_SRC*REG_AW){1'b0}};
      ex_used_r  <= enter_s ? id_rs_used_i : {NUM_SRC{1'b0}};
    end
  end

  // Saturating stall-cycle counter; frozen while held.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (!hold_i && stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end
  end

  assign ex_fwd_sel_o = fwd_sel_s;
  assign stall_o      = stall_s;
  assign stall_cnt_o  = stall_cnt_r;

endmodule
